// File: rtl/fsbx_bridge_if.sv
// Shrinked-AHB slave-side signal bundle between the CPU fabric and fsbx_bridge.
interface fsbx_bridge_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 24
) ();
  logic          hsel;
  logic          htrans;
  logic          hburst;
  logic          hwrite;
  logic [AW-1:0] haddr;
  logic [DW-1:0] hwdata;
  logic [DW-1:0] hrdata;
  logic          hready;
  logic          hresp;

  modport master (
    output hsel, htrans, hburst, hwrite, haddr, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  hsel, htrans, hburst, hwrite, haddr, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/fsbx_bridge.sv
// AHB-to-FSB bridge: multiplexed address/data bus with block-burst continuation,
// sync-mode timeout with AHB error response and a synchronised interrupt.
module fsbx_bridge #(
  parameter int unsigned DW      = 8,
  parameter int unsigned AW      = 24,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             hclk,
  input  logic             hreset_n,
  input  logic             sync_mode,
  input  logic [6:0]       async_waitcycle,
  fsbx_bridge_if.slave     ahb,
  output logic             ale_n,
  output logic             cs_n,
  output logic             cmd_n,
  output logic             typ,
  output logic             wr_n,
  input  logic             rdy_n,
  input  logic             irq_n,
  output logic             ad_dir,
  output logic [DW-1:0]    ad_out,
  input  logic [DW-1:0]    ad_in,
  output logic [AW-DW-1:0] aah,
  output logic             fsb_irq
);

  localparam int unsigned TW  = 10;
  localparam int unsigned INC = DW / 8;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_CMD, S_DONE, S_ERR1, S_ERR2
  } state_t;

  state_t r_state, w_next;

  // request / transfer context
  logic          r_pend,      w_pend_d;
  logic [AW-1:0] r_req_addr,  w_req_addr_d;
  logic          r_req_write, w_req_write_d;
  logic          r_req_burst, w_req_burst_d;
  logic [AW-1:0] r_cur_addr,  w_cur_addr_d;
  logic          r_cur_write, w_cur_write_d;
  logic          r_sync,      w_sync_d;
  logic [6:0]    r_cnt,       w_cnt_d;
  logic [TW-1:0] r_tmo,       w_tmo_d;
  logic          r_late,      w_late_d;

  // registered outputs
  logic             r_hready, w_hready_d;
  logic             r_hresp,  w_hresp_d;
  logic [DW-1:0]    r_hrdata, w_hrdata_d;
  logic             r_ale_n,  w_ale_n_d;
  logic             r_cs_n,   w_cs_n_d;
  logic             r_cmd_n,  w_cmd_n_d;
  logic             r_typ,    w_typ_d;
  logic             r_wr_n,   w_wr_n_d;
  logic             r_ad_dir, w_ad_dir_d;
  logic [DW-1:0]    r_ad_out, w_ad_out_d;
  logic [AW-DW-1:0] r_aah,    w_aah_d;
  logic             r_irq_s1, r_irq_s2;

  logic          w_accept;
  logic [AW-1:0] w_req_addr;
  logic          w_req_write;
  logic          w_req_burst;
  logic          w_start;
  logic          w_cont;

  // A request parked during DONE/ERR2 takes precedence over the live bus.
  assign w_accept    = ahb.hsel & ahb.htrans & r_hready;
  assign w_req_addr  = r_pend ? r_req_addr  : ahb.haddr;
  assign w_req_write = r_pend ? r_req_write : ahb.hwrite;
  assign w_req_burst = r_pend ? r_req_burst : ahb.hburst;
  assign w_start     = (r_state == S_IDLE) & (r_pend | w_accept);
  assign w_cont      = w_start & ~r_cs_n & r_typ & w_req_burst &
                       (w_req_write == r_cur_write) &
                       (w_req_addr == r_cur_addr + AW'(INC));

  // State register
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  // Next state and next values of all registered outputs/context
  always_comb begin
    w_next        = r_state;
    w_pend_d      = r_pend;
    w_req_addr_d  = r_req_addr;
    w_req_write_d = r_req_write;
    w_req_burst_d = r_req_burst;
    w_cur_addr_d  = r_cur_addr;
    w_cur_write_d = r_cur_write;
    w_sync_d      = r_sync;
    w_cnt_d       = r_cnt;
    w_tmo_d       = r_tmo;
    w_late_d      = r_late;
    w_hready_d    = r_hready;
    w_hresp_d     = r_hresp;
    w_hrdata_d    = r_hrdata;
    w_ale_n_d     = r_ale_n;
    w_cs_n_d      = r_cs_n;
    w_cmd_n_d     = r_cmd_n;
    w_typ_d       = r_typ;
    w_wr_n_d      = r_wr_n;
    w_ad_dir_d    = r_ad_dir;
    w_ad_out_d    = r_ad_out;
    w_aah_d       = r_aah;

    if (w_accept) begin
      w_req_addr_d  = ahb.haddr;
      w_req_write_d = ahb.hwrite;
      w_req_burst_d = ahb.hburst;
    end

    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_pend_d      = 1'b0;
          w_cur_addr_d  = w_req_addr;
          w_cur_write_d = w_req_write;
          w_sync_d      = sync_mode;
          w_cnt_d       = async_waitcycle;
          w_tmo_d       = '0;
          w_hready_d    = 1'b0;
          w_hresp_d     = 1'b0;
          if (w_cont) begin
            w_next     = S_CMD;
            w_ale_n_d  = 1'b1;
            w_cmd_n_d  = 1'b0;
            w_wr_n_d   = ~w_req_write;
            w_ad_dir_d = w_req_write;
            // Parked requests already have hwdata on the bus; live ones get it next cycle.
            if (w_req_write) begin
              if (r_pend) w_ad_out_d = ahb.hwdata;
              else        w_late_d   = 1'b1;
            end
          end else begin
            w_next     = S_ADDR;
            w_cs_n_d   = 1'b0;
            w_ale_n_d  = 1'b0;
            w_cmd_n_d  = 1'b1;
            w_wr_n_d   = 1'b1;
            w_ad_dir_d = 1'b1;
            w_ad_out_d = w_req_addr[DW-1:0];
            w_aah_d    = w_req_addr[AW-1:DW];
            w_typ_d    = w_req_burst;
          end
        end else begin
          w_cs_n_d   = 1'b1;
          w_typ_d    = 1'b0;
          w_hready_d = 1'b1;
          w_hresp_d  = 1'b0;
        end
      end

      S_ADDR: begin
        w_next     = S_CMD;
        w_ale_n_d  = 1'b1;
        w_cmd_n_d  = 1'b0;
        w_wr_n_d   = ~r_cur_write;
        w_ad_dir_d = r_cur_write;
        if (r_cur_write) w_ad_out_d = ahb.hwdata;
      end

      S_CMD: begin
        if (r_late) begin
          w_ad_out_d = ahb.hwdata;
          w_late_d   = 1'b0;
        end
        if (r_sync) begin
          if (!rdy_n) begin
            w_next = S_DONE;
          end else if (r_tmo == TMO_LAST) begin
            w_next = S_ERR1;
          end else begin
            w_tmo_d = r_tmo + TW'(1);
          end
        end else begin
          if (r_cnt == 7'd0) w_next = S_DONE;
          else               w_cnt_d = r_cnt - 7'd1;
        end
        if (w_next == S_DONE) begin
          w_cmd_n_d  = 1'b1;
          w_wr_n_d   = 1'b1;
          w_ad_dir_d = 1'b0;
          w_hready_d = 1'b1;
          w_hresp_d  = 1'b0;
          w_cs_n_d   = ~r_typ;
          if (!r_cur_write) w_hrdata_d = ad_in;
        end else if (w_next == S_ERR1) begin
          w_cmd_n_d  = 1'b1;
          w_wr_n_d   = 1'b1;
          w_cs_n_d   = 1'b1;
          w_typ_d    = 1'b0;
          w_ad_dir_d = 1'b0;
          w_hready_d = 1'b0;
          w_hresp_d  = 1'b1;
        end
      end

      S_DONE: begin
        w_next = S_IDLE;
        if (w_accept) begin
          w_pend_d   = 1'b1;
          w_hready_d = 1'b0;
        end
      end

      S_ERR1: begin
        w_next     = S_ERR2;
        w_hready_d = 1'b1;
        w_hresp_d  = 1'b1;
      end

      S_ERR2: begin
        w_next    = S_IDLE;
        w_hresp_d = 1'b0;
        if (w_accept) begin
          w_pend_d   = 1'b1;
          w_hready_d = 1'b0;
        end
      end

      default: w_next = S_IDLE;
    endcase
  end

  // Context and output registers
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_pend      <= 1'b0;
      r_req_addr  <= '0;
      r_req_write <= 1'b0;
      r_req_burst <= 1'b0;
      r_cur_addr  <= '0;
      r_cur_write <= 1'b0;
      r_sync      <= 1'b0;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_late      <= 1'b0;
      r_hready    <= 1'b1;
      r_hresp     <= 1'b0;
      r_hrdata    <= '0;
      r_ale_n     <= 1'b1;
      r_cs_n      <= 1'b1;
      r_cmd_n     <= 1'b1;
      r_typ       <= 1'b0;
      r_wr_n      <= 1'b1;
      r_ad_dir    <= 1'b0;
      r_ad_out    <= '0;
      r_aah       <= '0;
    end else begin
      r_pend      <= w_pend_d;
      r_req_addr  <= w_req_addr_d;
      r_req_write <= w_req_write_d;
      r_req_burst <= w_req_burst_d;
      r_cur_addr  <= w_cur_addr_d;
      r_cur_write <= w_cur_write_d;
      r_sync      <= w_sync_d;
      r_cnt       <= w_cnt_d;
      r_tmo       <= w_tmo_d;
      r_late      <= w_late_d;
      r_hready    <= w_hready_d;
      r_hresp     <= w_hresp_d;
      r_hrdata    <= w_hrdata_d;
      r_ale_n     <= w_ale_n_d;
      r_cs_n      <= w_cs_n_d;
      r_cmd_n     <= w_cmd_n_d;
      r_typ       <= w_typ_d;
      r_wr_n      <= w_wr_n_d;
      r_ad_dir    <= w_ad_dir_d;
      r_ad_out    <= w_ad_out_d;
      r_aah       <= w_aah_d;
    end
  end

  // Two-flop interrupt synchroniser; second stage stores the active-high level
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_irq_s1 <= 1'b1;
      r_irq_s2 <= 1'b0;
    end else begin
      r_irq_s1 <= irq_n;
      r_irq_s2 <= ~r_irq_s1;
    end
  end

  assign ahb.hrdata = r_hrdata;
  assign ahb.hready = r_hready;
  assign ahb.hresp  = r_hresp;
  assign ale_n      = r_ale_n;
  assign cs_n       = r_cs_n;
  assign cmd_n      = r_cmd_n;
  assign typ        = r_typ;
  assign wr_n       = r_wr_n;
  assign ad_dir     = r_ad_dir;
  assign ad_out     = r_ad_out;
  assign aah        = r_aah;
  assign fsb_irq    = r_irq_s2;

endmodule

// File: tb/tb_fsbx_bridge.sv
// Directed bench for fsbx_bridge: 8-bit and 16-bit instances side by side.
module tb_fsbx_bridge;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sync_mode;
  logic [6:0] waitc;
  logic       rdy_n;
  logic       irq_n;

  logic        p8_ale_n, p8_cs_n, p8_cmd_n, p8_typ, p8_wr_n, p8_ad_dir, p8_irq;
  logic [7:0]  p8_ad_out, p8_ad_in;
  logic [15:0] p8_aah;
  logic        p16_ale_n, p16_cs_n, p16_cmd_n, p16_typ, p16_wr_n, p16_ad_dir, p16_irq;
  logic [15:0] p16_ad_out, p16_ad_in;
  logic [7:0]  p16_aah;

  int n_chk  = 0;
  int n_fail = 0;

  fsbx_bridge_if #(.DW(8),  .AW(24)) a8 ();
  fsbx_bridge_if #(.DW(16), .AW(24)) a16 ();

  fsbx_bridge #(.DW(8), .AW(24), .TIMEOUT(8)) u8 (
    .hclk(clk), .hreset_n(rst_n), .sync_mode(sync_mode), .async_waitcycle(waitc),
    .ahb(a8.slave), .ale_n(p8_ale_n), .cs_n(p8_cs_n), .cmd_n(p8_cmd_n), .typ(p8_typ),
    .wr_n(p8_wr_n), .rdy_n(rdy_n), .irq_n(irq_n), .ad_dir(p8_ad_dir),
    .ad_out(p8_ad_out), .ad_in(p8_ad_in), .aah(p8_aah), .fsb_irq(p8_irq)
  );

  fsbx_bridge #(.DW(16), .AW(24), .TIMEOUT(8)) u16 (
    .hclk(clk), .hreset_n(rst_n), .sync_mode(sync_mode), .async_waitcycle(waitc),
    .ahb(a16.slave), .ale_n(p16_ale_n), .cs_n(p16_cs_n), .cmd_n(p16_cmd_n), .typ(p16_typ),
    .wr_n(p16_wr_n), .rdy_n(rdy_n), .irq_n(irq_n), .ad_dir(p16_ad_dir),
    .ad_out(p16_ad_out), .ad_in(p16_ad_in), .aah(p16_aah), .fsb_irq(p16_irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic req8(input logic [23:0] addr, input logic wr, input logic burst);
    a8.hsel = 1'b1; a8.htrans = 1'b1; a8.haddr = addr; a8.hwrite = wr; a8.hburst = burst;
  endtask

  task automatic req16(input logic [23:0] addr, input logic wr, input logic burst);
    a16.hsel = 1'b1; a16.htrans = 1'b1; a16.haddr = addr; a16.hwrite = wr; a16.hburst = burst;
  endtask

  task automatic idle_bus();
    a8.hsel = 1'b0;  a8.htrans = 1'b0;
    a16.hsel = 1'b0; a16.htrans = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sync_mode = 1'b0; waitc = 7'd0; rdy_n = 1'b1; irq_n = 1'b1;
    p8_ad_in = 8'h00; p16_ad_in = 16'h0000;
    a8.hsel = 1'b0; a8.htrans = 1'b0; a8.hburst = 1'b0; a8.hwrite = 1'b0;
    a8.haddr = '0; a8.hwdata = '0;
    a16.hsel = 1'b0; a16.htrans = 1'b0; a16.hburst = 1'b0; a16.hwrite = 1'b0;
    a16.haddr = '0; a16.hwdata = '0;

    // reset values
    #12;
    chk("rst_hready", 32'(a8.hready), 32'd1);
    chk("rst_hresp",  32'(a8.hresp),  32'd0);
    chk("rst_hrdata", 32'(a8.hrdata), 32'd0);
    chk("rst_pins8",  32'({p8_ale_n, p8_cs_n, p8_cmd_n, p8_wr_n, p8_typ, p8_ad_dir, p8_irq}), 32'b1111000);
    chk("rst_ad8",    32'({p8_aah, p8_ad_out}), 32'd0);
    chk("rst_ad16",   32'({p16_aah, p16_ad_out}), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    step();

    // async read, wc=2
    waitc = 7'd2; p8_ad_in = 8'hA5;
    req8(24'h123456, 1'b0, 1'b0);
    step();  // T0 -> ADDR
    idle_bus();
    chk("ar_ale",   32'(p8_ale_n), 32'd0);
    chk("ar_cs",    32'(p8_cs_n),  32'd0);
    chk("ar_adout", 32'(p8_ad_out), 32'h56);
    chk("ar_aah",   32'(p8_aah),   32'h1234);
    chk("ar_addir", 32'(p8_ad_dir), 32'd1);
    chk("ar_hrdy0", 32'(a8.hready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ar_cmd",   32'({p8_ale_n, p8_cmd_n, p8_ad_dir, a8.hready}), 32'b1000);
    end
    step();  // DONE
    chk("ar_hready", 32'(a8.hready), 32'd1);
    chk("ar_hrdata", 32'(a8.hrdata), 32'hA5);
    chk("ar_cmdend", 32'({p8_cmd_n, p8_cs_n}), 32'b11);
    step();

    // async write, wc=0
    waitc = 7'd0;
    req8(24'h000010, 1'b1, 1'b0);
    step();  // ADDR
    idle_bus();
    a8.hwdata = 8'h3C;
    chk("aw_adout_addr", 32'(p8_ad_out), 32'h10);
    step();  // CMD
    chk("aw_cmd", 32'({p8_ad_dir, p8_wr_n, p8_cmd_n, a8.hready}), 32'b1000);
    chk("aw_data", 32'(p8_ad_out), 32'h3C);
    step();  // DONE
    chk("aw_done", 32'({a8.hready, a8.hresp, p8_wr_n, p8_ad_dir}), 32'b1010);
    step();

    // sync read, rdy_n released after 4 CMD cycles
    sync_mode = 1'b1; p8_ad_in = 8'h77;
    req8(24'h000020, 1'b0, 1'b0);
    step();  // ADDR
    idle_bus();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("sr_wait", 32'({p8_cmd_n, a8.hready}), 32'b00);
    end
    rdy_n = 1'b0;
    step();  // DONE
    rdy_n = 1'b1;
    chk("sr_done", 32'({a8.hready, a8.hresp, p8_cmd_n}), 32'b101);
    chk("sr_data", 32'(a8.hrdata), 32'h77);
    step();

    // sync timeout: 8 CMD cycles, then ERR1, ERR2
    req8(24'h000030, 1'b0, 1'b0);
    step();  // ADDR
    idle_bus();
    for (int i = 0; i < 8; i++) begin
      step();
      chk("to_cmd", 32'({p8_cmd_n, a8.hready, a8.hresp}), 32'b000);
    end
    step();  // ERR1
    chk("to_err1", 32'({a8.hready, a8.hresp, p8_cs_n, p8_cmd_n, p8_ad_dir}), 32'b01110);
    step();  // ERR2
    chk("to_err2", 32'({a8.hready, a8.hresp, p8_cs_n}), 32'b111);
    step();  // IDLE
    chk("to_idle", 32'({a8.hready, a8.hresp}), 32'b10);
    sync_mode = 1'b0;

    // block burst on the 16-bit instance, wc=1
    waitc = 7'd1; p16_ad_in = 16'hBEEF;
    req16(24'h000100, 1'b0, 1'b1);
    step();  // ADDR
    idle_bus();
    chk("b1_addr", 32'({p16_ale_n, p16_cs_n, p16_typ}), 32'b001);
    chk("b1_adout", 32'(p16_ad_out), 32'h0100);
    chk("b1_aah", 32'(p16_aah), 32'h00);
    step(); step();  // CMD x2
    chk("b1_cmd2", 32'({p16_cmd_n, a16.hready}), 32'b00);
    step();  // DONE
    chk("b1_done", 32'({a16.hready, p16_cs_n}), 32'b10);
    chk("b1_data", 32'(a16.hrdata), 32'hBEEF);
    step();  // IDLE, chip select still held
    chk("b1_idle", 32'({p16_cs_n, a16.hready}), 32'b01);
    p16_ad_in = 16'h1234;
    req16(24'h000102, 1'b0, 1'b1);
    step();  // straight into CMD
    idle_bus();
    chk("b2_noale", 32'({p16_ale_n, p16_cmd_n, p16_cs_n, a16.hready}), 32'b1000);
    step();  // CMD2
    chk("b2_cmd2", 32'({p16_ale_n, p16_cmd_n, a16.hready}), 32'b100);
    step();  // DONE, one cycle earlier than the first
    chk("b2_done", 32'({a16.hready, p16_cs_n}), 32'b10);
    chk("b2_data", 32'(a16.hrdata), 32'h1234);
    step();  // IDLE
    req16(24'h000108, 1'b0, 1'b1);
    step();  // non-sequential -> ADDR
    idle_bus();
    chk("b3_ale", 32'(p16_ale_n), 32'd0);
    chk("b3_adout", 32'(p16_ad_out), 32'h0108);
    step(); step(); step();  // CMD x2, DONE
    chk("b3_done", 32'(a16.hready), 32'd1);
    step(); step();  // IDLE, then chip select drops
    chk("b3_release", 32'({p16_cs_n, p16_typ}), 32'b10);

    // reset pulse in the middle of CMD
    waitc = 7'd5;
    req8(24'h000040, 1'b0, 1'b0);
    step();
    idle_bus();
    step(); step();  // CMD2
    chk("rc_incmd", 32'({p8_cmd_n, p8_cs_n}), 32'b00);
    #2; rst_n = 1'b0; #1;
    chk("rc_async", 32'({p8_ale_n, p8_cs_n, p8_cmd_n, p8_wr_n, p8_ad_dir, a8.hready, a8.hresp}), 32'b1111010);
    @(posedge clk); #1; rst_n = 1'b1;
    step(); step();
    chk("rc_after", 32'({a8.hready, p8_cs_n, p8_cmd_n, a8.hrdata}), 32'({3'b111, 8'h00}));

    // interrupt synchroniser latency
    irq_n = 1'b0;
    step();
    chk("irq_edge1", 32'(p8_irq), 32'd0);
    step();
    chk("irq_edge2", 32'({p8_irq, p16_irq}), 32'b11);
    irq_n = 1'b1;
    step(); step();
    chk("irq_clear", 32'(p8_irq), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fsbx_bridge.md
Name: fsbx_bridge

Overview:
- Parametrised successor FSB bus controller: bridges the core's shrinked-AHB slave port to an external multiplexed address/data front-side bus.
- Generalised in data width (8/16), address width (24/32) and timeout.
- Adds sequential block-burst continuation (no re-ALE), bus timeout with AHB error response, and a synchronised IRQ output.
- Sits between the CPU AHB fabric and chip pins; on-chip function decode stays outside.

Parameters:
- DW, 8, external/AHB data width; 8 or 16 only.
- AW, 24, address width; 24 or 32 (32 when PAE enabled).
- TIMEOUT, 255, max CMD-phase cycles in sync mode before error; 1..1023.

Ports:
- hclk  in  1  single system clock; all logic on rising edge.
- hreset_n  in  1  asynchronous active-low reset.
- sync_mode  in  1  1 = rdy_n handshake, 0 = fixed wait count.
- async_waitcycle  in  7  extra CMD cycles in async mode.
- hsel  in  1  slave select.
- htrans  in  1  1 = active transfer.
- hburst  in  1  1 = continuation of sequential block.
- hwrite  in  1  1 = write.
- haddr  in  AW  byte address.
- hwdata  in  DW  write data, valid the cycle after acceptance.
- hrdata  out  DW  read data.
- hready  out  1  transfer done / ready to accept.
- hresp  out  1  1 = error.
- ale_n  out  1  address latch enable.
- cs_n  out  1  bus chip select.
- cmd_n  out  1  command strobe.
- typ  out  1  0 = single, 1 = block.
- wr_n  out  1  write strobe qualifier.
- rdy_n  in  1  external ready (sync mode).
- irq_n  in  1  external interrupt, asynchronous.
- ad_dir  out  1  1 = drive AD pins, 0 = hi-Z.
- ad_out  out  DW  multiplexed address low / write data.
- ad_in  in  DW  AD pin sample.
- aah  out  AW-DW  high address bits.
- fsb_irq  out  1  synchronised active-high interrupt.

Behaviour:
- Reset (async, hreset_n=0):
  - Outputs: hready=1, hresp=0, hrdata=0, ale_n=1, cs_n=1, cmd_n=1, wr_n=1, typ=0, ad_dir=0, ad_out=0, aah=0, fsb_irq=0.
  - Internal: FSM=IDLE, counters=0.
  - Reset mid-transfer aborts the transfer immediately; no completion is reported.
- Acceptance: hsel&htrans&hready sampled high at edge T0. Latch haddr, hwrite, hburst. hready=0 from T0+1.
- FSM states: IDLE, ADDR, CMD, DONE, ERR1, ERR2.
- IDLE -> ADDR on acceptance.
- IDLE -> CMD on acceptance when all hold: cs_n still low, previous transfer had typ=1, hburst=1, same hwrite, haddr = previous haddr + DW/8. This is burst continuation; no ALE.
- ADDR (1 cycle):
  - cs_n=0, ale_n=0, ad_dir=1, ad_out=haddr[DW-1:0], aah=haddr[AW-1:DW], typ=hburst.
  - Latch hwdata. Load wait counter=async_waitcycle; timeout counter=0. -> CMD.
- CMD:
  - ale_n=1, cmd_n=0, wr_n=~hwrite, ad_dir=hwrite, ad_out=write data.
  - Async mode: decrement counter; exit when counter==0. Total CMD cycles = async_waitcycle+1.
  - Sync mode: exit the cycle rdy_n sampled 0. Increment timeout counter each cycle; when it reaches TIMEOUT with rdy_n=1 -> ERR1.
  - On exit, hrdata<=ad_in (reads). -> DONE.
- DONE (1 cycle):
  - cmd_n=1, hready=1, hresp=0.
  - cs_n stays 0 if typ=1, else cs_n=1. -> IDLE.
  - A new request accepted in DONE is handled per the IDLE rules next cycle.
- ERR1: cmd_n=1, cs_n=1, ad_dir=0, hready=0, hresp=1. -> ERR2.
- ERR2: hready=1, hresp=1. -> IDLE; burst chain broken.
- In IDLE, cs_n returns to 1 one cycle after DONE if no continuation request arrives; typ cleared with it.
- Latency, async, non-burst: hready low for async_waitcycle+2 cycles, high with valid data in the following cycle. Burst continuation is one cycle shorter.
- ad_dir is never 1 in a cycle where the bus drives AD for a read (CMD read).
- Interrupt path: irq_n -> 2-flop synchroniser -> fsb_irq = ~sync. Latency 2 edges.
- Widths: DW=16 address increment is 2. aah width = AW-DW. sync_mode and async_waitcycle sampled at ADDR entry only.

Test Plan:
- Async read, DW=8, AW=24, async_waitcycle=2, haddr=0x123456, ad_in=0xA5 -> ale_n low 1 cycle with ad_out=0x56, aah=0x1234; cmd_n low 3 cycles; hrdata=0xA5 with hready=1 at T0+5.
- Async write, waitcycle=0, hwdata=0x3C -> ad_dir=1 in CMD, wr_n=0, ad_out=0x3C; hready high at T0+3.
- Sync read, rdy_n released after 4 CMD cycles -> DONE next cycle; hresp=0.
- Sync timeout, TIMEOUT=8, rdy_n stuck 1 -> ERR1 (hready=0, hresp=1), then ERR2 (hready=1, hresp=1); cs_n=1.
- Block burst, DW=16, reads at 0x000100, 0x000102 (hburst=1 on second) -> single ale_n pulse; cs_n held low across both; second hready one cycle earlier. A non-sequential 0x000108 -> new ALE.
- Reset pulse during CMD -> all outputs at reset values asynchronously. irq_n falling -> fsb_irq=1 after 2 edges.
